// File: rtl/cu_pkg.sv
// Shared encodings for the instruction-cycle controller:
// state codes, opcodes and accumulator source selects.
package cu_pkg;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_LOAD      = 4'd3,
    S_STORE     = 4'd4,
    S_ADD       = 4'd5,
    S_SUB       = 4'd6,
    S_INPUT     = 4'd7,
    S_INPUT_REL = 4'd8,
    S_JZ        = 4'd9,
    S_JPOS      = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

endpackage

// File: rtl/control_unit.sv
// Fetch/decode/execute controller: one state register and
// one combinational next-state and strobe block.
module control_unit
  import cu_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [2:0]      IR75,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic            Enter,
  output logic            IRload,
  output logic            PCload,
  output logic            IMPsel,
  output logic            MeminstSel,
  output logic            MemWr,
  output logic [1:0]      Asel,
  output logic            Aload,
  output logic            Sub,
  output logic            Halt,
  output logic [ST_W-1:0] State
);

  state_t state, nxt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= S_START;
    else        state <= nxt;
  end

  assign State = ST_W'(state);

  always_comb begin
    nxt        = S_HALT;
    IRload     = 1'b0;
    PCload     = 1'b0;
    IMPsel     = 1'b0;
    MeminstSel = 1'b0;
    MemWr      = 1'b0;
    Asel       = ASEL_ALU;
    Aload      = 1'b0;
    Sub        = 1'b0;
    Halt       = 1'b0;
    case (state)
      S_START: nxt = S_FETCH;
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
        nxt    = S_DECODE;
      end
      S_DECODE: begin
        MeminstSel = 1'b1;
        case (IR75)
          OP_LOAD:  nxt = S_LOAD;
          OP_STORE: nxt = S_STORE;
          OP_ADD:   nxt = S_ADD;
          OP_SUB:   nxt = S_SUB;
          OP_INPUT: nxt = S_INPUT;
          OP_JZ:    nxt = S_JZ;
          OP_JPOS:  nxt = S_JPOS;
          default:  nxt = S_HALT;
        endcase
      end
      S_LOAD: begin
        MeminstSel = 1'b1;
        Asel       = ASEL_MEM;
        Aload      = 1'b1;
        nxt        = S_FETCH;
      end
      S_STORE: begin
        MeminstSel = 1'b1;
        MemWr      = 1'b1;
        nxt        = S_FETCH;
      end
      S_ADD, S_SUB: begin
        MeminstSel = 1'b1;
        Aload      = 1'b1;
        Sub        = (state == S_SUB);
        nxt        = S_FETCH;
      end
      S_INPUT: begin
        nxt = S_INPUT;
        if (Enter) begin
          Asel  = ASEL_IN;
          Aload = 1'b1;
          nxt   = S_INPUT_REL;
        end
      end
      // wait for release so one press loads one value
      S_INPUT_REL: nxt = Enter ? S_INPUT_REL : S_FETCH;
      S_JZ: begin
        PCload = Aeq0;
        IMPsel = Aeq0;
        nxt    = S_FETCH;
      end
      S_JPOS: begin
        PCload = Apos;
        IMPsel = Apos;
        nxt    = S_FETCH;
      end
      S_HALT: begin
        Halt = 1'b1;
        nxt  = S_HALT;
      end
      default: nxt = S_HALT;
    endcase
  end

endmodule

// File: doc/control_unit.md
# control_unit

Finite-state controller for the instruction-cycle datapath. Consumes the opcode field `IR75` and the accumulator status flags. Produces every load, select and write strobe for the IR/PC fetch path and the accumulator/memory execute path. Runs a fixed fetch → decode → execute sequence per instruction, with a two-phase wait on the `Enter` handshake for input and a terminal halt.

## Interface
Parameters:
- `ST_W`, 4, width of the state register and of the `State` debug output.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset, asynchronous, active-low; drives the FSM to START.
- `IR75`  in  3  opcode field from the instruction register.
- `Aeq0`  in  1  accumulator equals zero.
- `Apos`  in  1  accumulator is strictly positive.
- `Enter`  in  1  synchronized, debounced input-ready level.
- `IRload`  out  1  load the instruction register.
- `PCload`  out  1  load the program counter.
- `IMPsel`  out  1  PC source select: 1 = IR[4:0] (jump target), 0 = PC+1.
- `MeminstSel`  out  1  memory address select: 1 = IR[4:0] (operand), 0 = PC.
- `MemWr`  out  1  memory write strobe (A → mem[IR[4:0]]).
- `Asel`  out  2  accumulator source: 00 adder/subtractor, 01 input port, 10 memory data, 11 unused.
- `Aload`  out  1  load the accumulator.
- `Sub`  out  1  adder mode: 1 = A − mem, 0 = A + mem.
- `Halt`  out  1  processor halted.
- `State`  out  ST_W  current state code, for debug.

## Operation
- Opcodes:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB.
  - 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
- States: START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, INPUT_REL, JZ, JPOS, HALT.
- Any output not listed for a state is 0.
- START: no outputs asserted. Next state is FETCH.
- FETCH: `IRload`=1, `PCload`=1, `IMPsel`=0, `MeminstSel`=0. IR captures mem[PC] and PC advances to PC+1. Next state is DECODE.
- DECODE: `MeminstSel`=1 so the operand address settles. Next state is chosen by `IR75`.
- LOAD: `MeminstSel`=1, `Asel`=10, `Aload`=1. Next state is FETCH.
- STORE: `MeminstSel`=1, `MemWr`=1. Next state is FETCH.
- ADD and SUB: `MeminstSel`=1, `Asel`=00, `Aload`=1. `Sub`=0 in ADD, 1 in SUB. Next state is FETCH.
- INPUT:
  - While `Enter`=0: no outputs asserted; stay in INPUT.
  - When `Enter`=1: `Asel`=01, `Aload`=1 in that same cycle; next state is INPUT_REL.
- INPUT_REL: no outputs asserted. Stay while `Enter`=1; go to FETCH when `Enter`=0. One press loads exactly one value.
- JZ: if `Aeq0`, assert `IMPsel`=1 and `PCload`=1. Next state is FETCH either way.
- JPOS: same as JZ, but conditioned on `Apos`.
- HALT: `Halt`=1. Stay in HALT until `clear` is asserted.
- Outputs are combinational from state, plus `Enter`/`Aeq0`/`Apos` in INPUT, JZ and JPOS. The state register is the only sequential element.

## Timing
- Reset: `clear`=0 forces state to START asynchronously. All outputs go to 0 and `State`=START code with no clock edge. START is left on the first rising edge after `clear` returns to 1.
- Reset mid-instruction: no partial completion. A strobe asserted in the current cycle drops immediately, and the pending edge has no effect.
- Cycles per instruction, including FETCH:
  - 3 for LOAD, STORE, ADD, SUB, JZ and JPOS.
  - INPUT: 3 + wait-for-press + wait-for-release, so 4 cycles minimum.
  - HALT: enters in 3 cycles and never exits.
- Flag sampling: `Aeq0` and `Apos` are sampled in the JZ/JPOS cycle only. They reflect A as loaded by the previous instruction.
- `Enter` already high on arrival in INPUT: the load happens in the first INPUT cycle.
- PC wrap-around (31 → 0) is the datapath's concern. The controller is unaffected.
- Opcode 111 and any unreachable state code decode to HALT.

## Structure
- Package `cu_pkg` holds:
  - state enum/localparams, 4-bit codes: START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, INPUT_REL=8, JZ=9, JPOS=10, HALT=11;
  - opcode constants;
  - `Asel` encodings.
- Single module with one state register and one combinational next-state/output block. No sub-module.

## Test plan
- Reset and fetch:
  - Stimulus: `clear`=0 mid-DECODE.
  - Response: all outputs 0 and `State`=0 immediately. After release: START, then FETCH with `IRload`=`PCload`=1 and `IMPsel`=`MeminstSel`=0.
- LOAD / STORE / ADD / SUB:
  - Stimulus: `IR75` = 000, 001, 010, 011 in turn.
  - Response: each completes in 3 cycles. LOAD drives `Asel`=10, `Aload`=1. STORE drives `MemWr`=1 only. ADD drives `Asel`=00, `Sub`=0. SUB drives `Sub`=1. `MeminstSel`=1 in DECODE and in execute.
- JZ:
  - Stimulus: `IR75`=101 with `Aeq0`=1.
  - Response: `PCload`=`IMPsel`=1 in the JZ cycle. Repeating with `Aeq0`=0 gives `PCload`=0.
  - Repeat for JPOS (`IR75`=110) using `Apos`.
- INPUT handshake:
  - Stimulus: `IR75`=100 with `Enter` low for 5 cycles, then high for 3, then low.
  - Response: `Aload` pulses exactly once, with `Asel`=01, on the first high cycle. FETCH follows the cycle after `Enter` falls.
- INPUT with early press:
  - Stimulus: `Enter` already 1 on entry to INPUT.
  - Response: immediate single load, then hold in INPUT_REL.
- HALT:
  - Stimulus: `IR75`=111, run 20 cycles, then toggle `clear`.
  - Response: `Halt`=1 and no strobes throughout; returns to START.
